// File: rtl/sbox_fill_ctrl.sv
// rtl/sbox_fill_ctrl.sv - fills a 256-entry byte S-box with unique chaos bytes
// Optional SBOX_INV_WRITE_EN adds an inverse S-box write port driven in the same pass.
module sbox_fill_ctrl #(
    parameter int REJ_W      = 16,
    parameter int MAX_REJECT = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             chaos_valid,
    input  logic [7:0]       chaos_data,
    output logic             chaos_ready,
    output logic             sbox_we,
    output logic [7:0]       sbox_addr,
    output logic [7:0]       sbox_wdata,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [REJ_W-1:0] reject_cnt
`ifdef SBOX_INV_WRITE_EN
    ,
    output logic             inv_we,
    output logic [7:0]       inv_addr,
    output logic [7:0]       inv_wdata
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [REJ_W-1:0] REJ_LIMIT = REJ_W'(MAX_REJECT);

    state_t       state;
    logic [255:0] used;
    logic [8:0]   count;
    logic         is_dup;

    // The bitmap is updated on the accept edge, so a byte accepted in the
    // following cycle already sees it: repeats on consecutive cycles write once.
    assign is_dup = used[chaos_data];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            used        <= '0;
            count       <= '0;
            chaos_ready <= 1'b0;
            sbox_we     <= 1'b0;
            sbox_addr   <= '0;
            sbox_wdata  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            reject_cnt  <= '0;
`ifdef SBOX_INV_WRITE_EN
            inv_we      <= 1'b0;
            inv_addr    <= '0;
            inv_wdata   <= '0;
`endif
        end else begin
            sbox_we <= 1'b0;
`ifdef SBOX_INV_WRITE_EN
            inv_we  <= 1'b0;
`endif
            case (state)
                S_FILL: begin
                    if (chaos_valid) begin
                        if (!is_dup) begin
                            used[chaos_data] <= 1'b1;
                            sbox_we          <= 1'b1;
                            sbox_addr        <= count[7:0];
                            sbox_wdata       <= chaos_data;
`ifdef SBOX_INV_WRITE_EN
                            inv_we           <= 1'b1;
                            inv_addr         <= chaos_data;
                            inv_wdata        <= count[7:0];
`endif
                            count            <= count + 9'd1;
                            reject_cnt       <= '0;
                            if (count == 9'd255) begin
                                state       <= S_DONE;
                                busy        <= 1'b0;
                                chaos_ready <= 1'b0;
                                done        <= 1'b1;
                            end
                        end else begin
                            reject_cnt <= reject_cnt + 1'b1;
                            if (reject_cnt + 1'b1 == REJ_LIMIT) begin
                                state       <= S_ERROR;
                                busy        <= 1'b0;
                                chaos_ready <= 1'b0;
                                error       <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state       <= S_FILL;
                        used        <= '0;
                        count       <= '0;
                        reject_cnt  <= '0;
                        busy        <= 1'b1;
                        chaos_ready <= 1'b1;
                        done        <= 1'b0;
                        error       <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sbox_fill_ctrl.sv
// tb/tb_sbox_fill_ctrl.sv - randomized self-checking bench for sbox_fill_ctrl
// Define SBOX_INV_WRITE_EN to also exercise the inverse write port.
module tb_sbox_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        chaos_valid = 1'b0;
    logic [7:0]  chaos_data = 8'h00;
    logic        chaos_ready, sbox_we, busy, done, error;
    logic [7:0]  sbox_addr, sbox_wdata;
    logic [15:0] reject_cnt;
`ifdef SBOX_INV_WRITE_EN
    logic        inv_we;
    logic [7:0]  inv_addr, inv_wdata;
`endif

    logic        start4 = 1'b0;
    logic        valid4 = 1'b0;
    logic [7:0]  data4 = 8'h00;
    logic        ready4, we4, busy4, done4, error4;
    logic [7:0]  addr4, wdata4;
    logic [15:0] rej4;

    sbox_fill_ctrl #(.REJ_W(16), .MAX_REJECT(4096)) dut (
        .clk(clk), .rst(rst), .start(start), .chaos_valid(chaos_valid),
        .chaos_data(chaos_data), .chaos_ready(chaos_ready), .sbox_we(sbox_we),
        .sbox_addr(sbox_addr), .sbox_wdata(sbox_wdata), .busy(busy), .done(done),
        .error(error), .reject_cnt(reject_cnt)
`ifdef SBOX_INV_WRITE_EN
        , .inv_we(inv_we), .inv_addr(inv_addr), .inv_wdata(inv_wdata)
`endif
    );

    sbox_fill_ctrl #(.REJ_W(16), .MAX_REJECT(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .chaos_valid(valid4),
        .chaos_data(data4), .chaos_ready(ready4), .sbox_we(we4),
        .sbox_addr(addr4), .sbox_wdata(wdata4), .busy(busy4), .done(done4),
        .error(error4), .reject_cnt(rej4)
`ifdef SBOX_INV_WRITE_EN
        , .inv_we(), .inv_addr(), .inv_wdata()
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: 0 idle, 1 fill, 2 done, 3 error
    localparam int MAXR = 4096;
    int          m_state;
    bit          m_used[256];
    int          m_count;
    logic [15:0] m_rej;
    logic        m_we;
    logic [7:0]  m_addr, m_wdata;

    task automatic model_reset();
        m_state = 0; m_count = 0; m_rej = '0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        for (int i = 0; i < 256; i++) m_used[i] = 1'b0;
    endtask

    function automatic logic [36:0] exp_vec();
        return {m_we, m_addr, m_wdata, m_state == 1, m_state == 2, m_state == 3, m_state == 1, m_rej};
    endfunction

    function automatic logic [36:0] act_vec();
        return {sbox_we, sbox_addr, sbox_wdata, busy, done, error, chaos_ready, reject_cnt};
    endfunction

    task automatic cycle(input bit s, input bit v, input logic [7:0] d);
        start = s; chaos_valid = v; chaos_data = d;
        @(posedge clk);
        m_we = 1'b0;
        if (m_state != 1 && s) begin
            model_reset();
            m_state = 1;
        end else if (m_state == 1 && v) begin
            if (!m_used[d]) begin
                m_used[d] = 1'b1;
                m_we = 1'b1; m_addr = 8'(m_count); m_wdata = d;
                m_count++; m_rej = '0;
                if (m_count == 256) m_state = 2;
            end else begin
                m_rej = m_rej + 16'd1;
                if (int'(m_rej) == MAXR) m_state = 3;
            end
        end
        #1;
        start = 1'b0; chaos_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        model_reset();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (act_vec() !== 37'h0) begin
            errors++; $display("FAIL reset_outputs got %h want 0", act_vec());
        end
        checks++;
        if ({we4, addr4, wdata4, busy4, done4, error4, ready4, rej4} !== 37'h0) begin
            errors++; $display("FAIL reset_outputs_dut4 nonzero");
        end
`ifdef SBOX_INV_WRITE_EN
        checks++;
        if ({inv_we, inv_addr, inv_wdata} !== 17'h0) begin
            errors++; $display("FAIL reset_inv got %h want 0", {inv_we, inv_addr, inv_wdata});
        end
`endif
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_ascending();
        int nwr = 0;
        cycle(1'b1, 1'b0, 8'h00);
        checks++;
        if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL asc_start got %h want %h", act_vec(), exp_vec());
        end
        for (int i = 0; i < 256; i++) begin
            cycle(1'b0, 1'b1, 8'(i));
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL asc_vec i=%0d got %h want %h", i, act_vec(), exp_vec());
            end
            checks++;
            if (sbox_we !== 1'b1 || sbox_addr !== 8'(i) || sbox_wdata !== 8'(i)) begin
                errors++; $display("FAIL asc_write i=%0d got we=%b addr=%h data=%h", i, sbox_we, sbox_addr, sbox_wdata);
            end
            if (sbox_we === 1'b1) nwr++;
        end
        checks++;
        if ({done, chaos_ready, error, busy} !== 4'b1000) begin
            errors++; $display("FAIL asc_done got done/ready/err/busy=%b want 1000", {done, chaos_ready, error, busy});
        end
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if ({done, chaos_ready, sbox_we} !== 3'b100) begin
            errors++; $display("FAIL asc_after_done got done/ready/we=%b want 100", {done, chaos_ready, sbox_we});
        end
        checks++;
        if (nwr !== 256) begin
            errors++; $display("FAIL asc_write_count got %0d want 256", nwr);
        end
    endtask

    task automatic test_random();
        int  nwr = 0;
        int  cyc = 0;
        bit  seen[256];
        bit  bad_addr = 1'b0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        cycle(1'b1, 1'b0, 8'h00);
        while (m_state == 1 && cyc < 20000) begin
            cycle($urandom_range(0, 49) == 0, 1'($urandom_range(0, 1)), 8'($urandom));
            cyc++;
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                if (errors < 20) $display("FAIL rand_vec cyc=%0d got %h want %h", cyc, act_vec(), exp_vec());
            end
            if (sbox_we === 1'b1) begin
                if (sbox_addr !== 8'(nwr) || seen[sbox_wdata]) bad_addr = 1'b1;
                seen[sbox_wdata] = 1'b1;
                nwr++;
            end
        end
        checks++;
        if (cyc >= 20000) begin
            errors++; $display("FAIL rand_timeout got %0d cycles want < 20000", cyc);
        end
        checks++;
        if (bad_addr || nwr !== 256) begin
            errors++; $display("FAIL rand_perm got writes=%0d order_or_repeat_bad=%b want 256/0", nwr, bad_addr);
        end
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL rand_done got %b want 1", done);
        end
    endtask

    task automatic test_duplicates();
        logic [7:0] seq[4];
        seq[0] = 8'h05; seq[1] = 8'h05; seq[2] = 8'h05; seq[3] = 8'h07;
        do_reset();
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, seq[i]);
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL dup_vec i=%0d got %h want %h", i, act_vec(), exp_vec());
            end
            if (i == 1) begin
                checks++;
                if (sbox_we !== 1'b0 || reject_cnt !== 16'd1) begin
                    errors++; $display("FAIL back_to_back got we=%b rej=%0d want 0/1", sbox_we, reject_cnt);
                end
            end
            if (i == 2) begin
                checks++;
                if (reject_cnt !== 16'd2) begin
                    errors++; $display("FAIL dup_rej got %0d want 2", reject_cnt);
                end
            end
        end
        checks++;
        if ({sbox_we, sbox_addr, sbox_wdata, reject_cnt} !== {1'b1, 8'h01, 8'h07, 16'd0}) begin
            errors++; $display("FAIL dup_second_write got we=%b addr=%h data=%h rej=%0d want 1/01/07/0", sbox_we, sbox_addr, sbox_wdata, reject_cnt);
        end
    endtask

    task automatic test_max_reject();
        @(posedge clk); #1;
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0; valid4 = 1'b1; data4 = 8'h10;
        @(posedge clk); #1;
        checks++;
        if ({we4, addr4, wdata4} !== {1'b1, 8'h00, 8'h10}) begin
            errors++; $display("FAIL maxrej_write got we=%b addr=%h data=%h want 1/00/10", we4, addr4, wdata4);
        end
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (k < 4 && {we4, rej4, error4, ready4, busy4} !== {1'b0, 16'(k), 3'b011}) begin
                errors++; $display("FAIL maxrej_dup k=%0d got we=%b rej=%0d err=%b ready=%b", k, we4, rej4, error4, ready4);
            end
            if (k == 4 && {we4, rej4, error4, ready4, busy4} !== {1'b0, 16'd4, 3'b100}) begin
                errors++; $display("FAIL maxrej_error got we=%b rej=%0d err=%b ready=%b busy=%b want 0/4/1/0/0", we4, rej4, error4, ready4, busy4);
            end
        end
        valid4 = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({error4, rej4} !== {1'b1, 16'd4}) begin
            errors++; $display("FAIL maxrej_hold got err=%b rej=%0d want 1/4", error4, rej4);
        end
        start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        checks++;
        if ({busy4, error4, ready4, rej4} !== {3'b101, 16'd0}) begin
            errors++; $display("FAIL maxrej_restart got busy=%b err=%b ready=%b rej=%0d want 1/0/1/0", busy4, error4, ready4, rej4);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b1, 8'(i * 7));
            checks++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL mid_vec i=%0d got %h want %h", i, act_vec(), exp_vec());
            end
        end
        #1 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (act_vec() !== 37'h0) begin
            errors++; $display("FAIL mid_reset_outputs got %h want 0", act_vec());
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        cycle(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 8'(i * 7));
            checks++;
            if (act_vec() !== exp_vec() || sbox_we !== 1'b1 || sbox_addr !== 8'(i)) begin
                errors++; $display("FAIL mid_refill i=%0d got %h want %h", i, act_vec(), exp_vec());
            end
        end
    endtask

`ifdef SBOX_INV_WRITE_EN
    task automatic test_inv();
        do_reset();
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b0, 1'b1, 8'hFF);
        checks++;
        if ({inv_we, inv_addr, inv_wdata, sbox_we} !== {1'b1, 8'hFF, 8'h00, 1'b1}) begin
            errors++; $display("FAIL inv_first got we=%b addr=%h data=%h want 1/FF/00", inv_we, inv_addr, inv_wdata);
        end
        cycle(1'b0, 1'b1, 8'h00);
        checks++;
        if ({inv_we, inv_addr, inv_wdata, sbox_we} !== {1'b1, 8'h00, 8'h01, 1'b1}) begin
            errors++; $display("FAIL inv_second got we=%b addr=%h data=%h want 1/00/01", inv_we, inv_addr, inv_wdata);
        end
        cycle(1'b0, 1'b0, 8'h00);
        checks++;
        if ({inv_we, inv_addr, inv_wdata} !== {1'b0, 8'h00, 8'h01}) begin
            errors++; $display("FAIL inv_hold got we=%b addr=%h data=%h want 0/00/01", inv_we, inv_addr, inv_wdata);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_ascending();
        test_random();
        test_duplicates();
        test_max_reject();
        test_reset_mid();
`ifdef SBOX_INV_WRITE_EN
        test_inv();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
